// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder
// Purpose  : RV32I instruction assembler. Packs register fields and a 32-bit
//            immediate into an instruction word for the selected format, flags
//            immediates that the format cannot represent, and queues results
//            in a small valid/ready FIFO.
// Ports    : clk_i, rst_i            - clock / async active-high reset
//            valid_i, ready_o        - request handshake
//            fmt_i .. imm_i          - instruction fields (fmt 0..6 = R,I,
//                                      I-shift,S,B,U,J; 7 = reserved)
//            valid_o, ready_i        - result handshake (pop on both high)
//            inst_o, err_o           - head-of-FIFO result (0 when empty)
//            err_cnt_o               - saturating count of pushed error entries
// Revision : 1.0 - initial release
// ============================================================================
module inst_encoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       fmt_i,
  input  logic [6:0]       opcode_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  inst_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_IS = 3'd2;
  localparam logic [2:0] FMT_S  = 3'd3;
  localparam logic [2:0] FMT_B  = 3'd4;
  localparam logic [2:0] FMT_U  = 3'd5;
  localparam logic [2:0] FMT_J  = 3'd6;

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  logic [31:0] enc_inst;
  logic        enc_err;

  // A two's-complement value fits in N bits when all bits from N-1 upward are
  // copies of the sign bit (all zeros or all ones).
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    enc_inst = NOP;
    enc_err  = 1'b1;
    case (fmt_i)
      FMT_R: begin
        enc_inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        enc_err  = 1'b0;
      end
      FMT_I: begin
        enc_inst = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_err  = ~fits12;
      end
      FMT_IS: begin
        enc_inst = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_err  = |imm_i[31:5];
      end
      FMT_S: begin
        enc_inst = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        enc_err  = ~fits12;
      end
      FMT_B: begin
        enc_inst = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                    imm_i[4:1], imm_i[11], opcode_i};
        enc_err  = imm_i[0] | ~fits13;
      end
      FMT_U: begin
        enc_inst = {imm_i[31:12], rd_i, opcode_i};
        enc_err  = |imm_i[11:0];
      end
      FMT_J: begin
        enc_inst = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                    rd_i, opcode_i};
        enc_err  = imm_i[0] | ~fits21;
      end
      default: begin
        enc_inst = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [31:0]    mem_inst [DEPTH];
  logic           mem_err  [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [CNT_W-1:0] err_cnt;

  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count != '0);
  // No bypass: a full FIFO refuses a request even if the head pops this cycle.
  assign ready_o   = (count < FULL_CNT);
  assign push      = valid_i & ready_o;
  assign pop       = not_empty & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= enc_inst;
        mem_err[wr_ptr]  <= enc_err;
        wr_ptr           <= wr_ptr + 1'b1;
        if (enc_err && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign valid_o   = not_empty;
  assign inst_o    = not_empty ? XLEN'(mem_inst[rd_ptr]) : '0;
  assign err_o     = not_empty ? mem_err[rd_ptr] : 1'b0;
  assign err_cnt_o = err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_encoder
// Purpose  : Directed self-checking bench for inst_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int checks   = 0;
  int failures = 0;

  inst_encoder #(.XLEN(32), .DEPTH(2), .CNT_W(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .fmt_i    (fmt_i),
    .opcode_i (opcode_i),
    .rd_i     (rd_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .imm_i    (imm_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .inst_o   (inst_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    valid_i  = 1'b1;
    fmt_i    = f;
    opcode_i = op;
    rd_i     = rd;
    rs1_i    = rs1;
    rs2_i    = rs2;
    funct3_i = f3;
    funct7_i = f7;
    imm_i    = imm;
  endtask

  // One request into an empty FIFO with ready_i=1: result visible one cycle
  // later, popped on the following edge.
  task automatic single(input string tag, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic exp_err,
                        input logic [7:0] exp_cnt);
    drive(f, op, rd, rs1, rs2, f3, f7, imm);
    tick();
    valid_i = 1'b0;
    check({tag, ".valid"}, 32'(valid_o), 32'd1);
    check({tag, ".inst"}, inst_o, exp_inst);
    check({tag, ".err"}, 32'(err_o), 32'(exp_err));
    check({tag, ".cnt"}, 32'(err_cnt_o), 32'(exp_cnt));
    tick();
    check({tag, ".drained"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    rst_i   = 1'b1;
    ready_i = 1'b0;
    drive(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    valid_i = 1'b0;
    tick();
    tick();
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.inst", inst_o, 32'd0);
    check("rst.err", 32'(err_o), 32'd0);
    check("rst.cnt", 32'(err_cnt_o), 32'd0);
    check("rst.ready", 32'(ready_o), 32'd1);
    rst_i = 1'b0;
    tick();

    // ---------------- encoding vectors ----------------
    ready_i = 1'b1;
    single("I_neg1",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 8'd0);
    single("R_sub",   3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h4020_81B3, 1'b0, 8'd0);
    single("I_2048",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h8000_0093, 1'b1, 8'd1);
    single("IS_3",    3'd2, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'h20, 32'd3,        32'h4031_1093, 1'b0, 8'd1);
    single("IS_32",   3'd2, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'h20, 32'd32,       32'h4001_1093, 1'b1, 8'd2);
    single("S_m4",    3'd3, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0, 8'd2);
    single("B_8",     3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8,        32'h0020_8463, 1'b0, 8'd2);
    single("B_3",     3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h0020_8163, 1'b1, 8'd3);
    single("B_4096",  3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd4096,     32'h8020_8063, 1'b1, 8'd4);
    single("U_ok",    3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0, 8'd4);
    single("U_low",   3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1'b1, 8'd5);
    single("J_800",   3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0, 8'd5);
    single("J_2p20",  3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_00EF, 1'b1, 8'd6);
    single("RSV",     3'd7, 7'h33, 5'd9, 5'd1, 5'd2, 3'd7, 7'h7F, 32'h1234_5678, 32'h0000_0013, 1'b1, 8'd7);

    // ---------------- backpressure ----------------
    ready_i = 1'b0;
    drive(3'd0, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);   // A
    tick();
    check("bp.ready_after1", 32'(ready_o), 32'd1);
    drive(3'd0, 7'h33, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);   // B
    tick();
    check("bp.ready_full", 32'(ready_o), 32'd0);
    drive(3'd0, 7'h33, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);   // C, held
    tick();
    check("bp.still_full", 32'(ready_o), 32'd0);
    check("bp.head_A", inst_o, 32'h0000_00B3);
    ready_i = 1'b1;
    tick();                                                       // pop A, C refused
    check("bp.head_B", inst_o, 32'h0000_0133);
    check("bp.ready_free", 32'(ready_o), 32'd1);
    tick();                                                       // pop B, push C
    valid_i = 1'b0;
    check("bp.head_C", inst_o, 32'h0000_01B3);
    check("bp.valid_C", 32'(valid_o), 32'd1);
    tick();
    check("bp.empty", 32'(valid_o), 32'd0);
    check("bp.empty_inst", inst_o, 32'd0);

    // ---------------- concurrent push/pop ----------------
    ready_i = 1'b0;
    drive(3'd0, 7'h33, 5'd20, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    tick();
    ready_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("cc.head%0d", k - 1), inst_o, 32'h33 | (32'(20 + k - 1) << 7));
      drive(3'd0, 7'h33, 5'(20 + k), 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
      tick();
      check($sformatf("cc.valid%0d", k), 32'(valid_o), 32'd1);
      check($sformatf("cc.ready%0d", k), 32'(ready_o), 32'd1);
    end
    valid_i = 1'b0;
    check("cc.last", inst_o, 32'h33 | (32'd30 << 7));
    tick();
    check("cc.empty", 32'(valid_o), 32'd0);

    // ---------------- reset mid-stream ----------------
    ready_i = 1'b0;
    drive(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    tick();
    drive(3'd0, 7'h33, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    tick();
    check("mr.full", 32'(ready_o), 32'd0);
    check("mr.cnt_pre", 32'(err_cnt_o), 32'd8);
    rst_i = 1'b1;                                                // valid_i still high
    #1;
    check("mr.valid", 32'(valid_o), 32'd0);
    check("mr.inst", inst_o, 32'd0);
    check("mr.cnt", 32'(err_cnt_o), 32'd0);
    tick();
    rst_i   = 1'b0;
    valid_i = 1'b0;
    tick();
    check("mr.ready", 32'(ready_o), 32'd1);
    check("mr.noentry", 32'(valid_o), 32'd0);

    // ---------------- error counter saturation ----------------
    ready_i = 1'b1;
    drive(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 253) check("sat.254", 32'(err_cnt_o), 32'd254);
    end
    valid_i = 1'b0;
    check("sat.cnt", 32'(err_cnt_o), 32'd255);
    tick();
    check("sat.drain", 32'(valid_o), 32'd0);
    check("sat.hold", 32'(err_cnt_o), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Instruction assembler: packs register fields and a 32-bit immediate into a 32-bit RV32I instruction word for a selected format. It is the inverse of the immediate decode path.
- Checks that the immediate is representable in that format and flags any violation.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Used by the self-test/boot sequencer and by testbenches to generate instruction streams for the core.

Parameters:
XLEN, 32, data/instruction width (only 32 supported)
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 8, width of error counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
valid_i  input  1  request valid
ready_o  output  1  request accepted when valid_i && ready_o
fmt_i  input  3  0=R,1=I,2=I-shift,3=S,4=B,5=U,6=J,7=reserved
opcode_i  input  7  inst[6:0]
rd_i  input  5  destination register
rs1_i  input  5  source 1
rs2_i  input  5  source 2
funct3_i  input  3  funct3
funct7_i  input  7  funct7 (R, I-shift)
imm_i  input  XLEN  byte-offset/value immediate, two's complement
valid_o  output  1  FIFO head valid
ready_i  input  1  consumer ready; pop when valid_o && ready_i
inst_o  output  XLEN  encoded instruction at head
err_o  output  1  head entry's immediate was not representable
err_cnt_o  output  CNT_W  saturating count of accepted error entries

Behaviour:
- Reset (async assert, sync release): FIFO empty, valid_o=0, inst_o=0, err_o=0, err_cnt_o=0, ready_o=1.
- ready_o = (count < DEPTH). No bypass: when full, ready_o=0 even if ready_i=1 in the same cycle.
- Accepted request is encoded combinationally and written to the FIFO tail at that edge. valid_o goes high the following cycle. Latency is 1 cycle when empty.
- Simultaneous push and pop when not full: count unchanged, order preserved.
- inst_o and err_o come straight from registered storage at the head. When empty they read 0.
- Encodings (imm = imm_i):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}. err=0.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. err if imm outside [-2048, 2047].
  - I-shift: {funct7, imm[4:0], rs1, funct3, rd, opcode}. err if imm[31:5] != 0.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. err if outside [-2048, 2047].
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. err if imm[0]=1 or outside [-4096, 4095].
  - U: {imm[31:12], rd, opcode}. err if imm[11:0] != 0.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. err if imm[0]=1 or outside [-2^20, 2^20-1].
  - reserved: inst = 32'h0000_0013 (NOP), err=1.
- Error entries are still pushed. inst holds the truncated encoding and err=1.
- err_cnt_o increments by 1 at each accepted push with err=1. It saturates at 2^CNT_W-1.
- Pointers wrap modulo DEPTH. Count needs log2(DEPTH)+1 bits.
- valid_i while ready_o=0 is ignored. Inputs need not be held stable.
- Reset mid-operation discards all entries immediately. In-flight inputs are not captured.

Test Plan:
- I: fmt=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> next cycle valid_o=1, inst_o=0xFFF00093, err_o=0.
- B: fmt=4, opcode=0x63, rs1=1, rs2=2, f3=0, imm=8 -> inst_o=0x00208463. Then imm=3 -> err_o=1, err_cnt_o=1. Then imm=4096 -> err_o=1, err_cnt_o=2.
- U/J/reserved:
  - U imm=0x12345000, rd=5, opcode=0x37 -> 0x123452B7, err 0.
  - J imm=0x800, rd=1, opcode=0x6F -> 0x001000EF, err 0.
  - fmt=7 -> 0x00000013, err 1.
- Backpressure: ready_i=0, push 3 requests back-to-back -> ready_o=0 after 2 accepted, third held. Raise ready_i -> outputs appear in order, one per cycle, and third is accepted after the first pop.
- Concurrent push/pop with FIFO holding 1: one push and one pop per cycle for 10 cycles -> count stays 1 and outputs are in order. Pointer wrap is exercised.
- Assert rst_i mid-stream with 2 entries queued -> valid_o=0, inst_o=0, err_cnt_o=0 immediately, ready_o=1 after release.
